// File: rtl/nonoverlap_pkg.sv
// -----------------------------------------------------------------------------
// nonoverlap_pkg
//   Shared types and defaults for the multi-channel dead-time generator.
//   - dt_state_t     : per-channel FSM state (IDLE follows inputs, DEAD forces low)
//   - DEFAULT_NUM_CH : default number of half-bridge channels
//   - DEFAULT_CNT_W  : default dead-time counter width
// -----------------------------------------------------------------------------
package nonoverlap_pkg;

  localparam int DEFAULT_NUM_CH = 2;
  localparam int DEFAULT_CNT_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    DEAD = 1'b1
  } dt_state_t;

endpackage : nonoverlap_pkg

// File: rtl/nonoverlap_ch.sv
// -----------------------------------------------------------------------------
// nonoverlap_ch
//   One half-bridge channel of the dead-time generator. Any edge on the
//   high/low command (or a global enable rising edge) opens a dead window in
//   which both gate drives are held low for dtLatched+1 cycles; afterwards the
//   registered outputs follow the commands with one cycle of latency. A
//   command pair with both sides asserted forces both outputs low for that
//   cycle and sets a sticky fault flag.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   en          global enable; low forces outputs low and the FSM to IDLE
//   enRise      one-cycle pulse on the enable rising edge (opens a window)
//   dtCfg       dead time, sampled only when a window opens or restarts
//   clrFault    synchronous clear of the sticky fault flag
//   highIn      high-side command
//   lowIn       low-side command
//   highOut     high-side gate drive (registered)
//   lowOut      low-side gate drive (registered)
//   inDead      1 while the channel is in its dead window (registered)
//   fault       sticky shoot-through flag
// -----------------------------------------------------------------------------
module nonoverlap_ch
  import nonoverlap_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             enRise,
  input  logic [CNT_W-1:0] dtCfg,
  input  logic             clrFault,
  input  logic             highIn,
  input  logic             lowIn,
  output logic             highOut,
  output logic             lowOut,
  output logic             inDead,
  output logic             fault
);

  dt_state_t        state;
  dt_state_t        nextState;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nextCnt;
  logic [CNT_W-1:0] dtLatched;
  logic [CNT_W-1:0] nextDt;
  logic             highD;
  logic             lowD;
  logic             chg;
  logic             shoot;
  logic             passOut;

  // An enable rising edge is treated exactly like a command edge so the
  // bridge never turns on without first passing through a dead window.
  assign chg   = (highIn ^ highD) | (lowIn ^ lowD) | enRise;
  assign shoot = highIn & lowIn;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred; combinational logic uses '='.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    nextDt    = dtLatched;
    passOut   = 1'b0;
    if (!en) begin
      nextState = IDLE;
      nextCnt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (chg) begin
            nextState = DEAD;
            nextCnt   = '0;
            nextDt    = dtCfg;
          end else begin
            passOut = 1'b1;
          end
        end
        DEAD: begin
          if (chg) begin
            // A new edge inside the window restarts it with a fresh dead time.
            nextCnt = '0;
            nextDt  = dtCfg;
          end else if (cnt == dtLatched) begin
            nextState = IDLE;
            passOut   = 1'b1;
          end else begin
            nextCnt = cnt + 1'b1;
          end
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
  end

  // NOTE: state is updated with '<=' so every register samples the values
  // from before this edge regardless of statement order.
  // NOTE: all registers here are control state and are asynchronously reset;
  // there is no storage array that would need to be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dtLatched <= '0;
      highD     <= 1'b0;
      lowD      <= 1'b0;
      highOut   <= 1'b0;
      lowOut    <= 1'b0;
      inDead    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      highD     <= highIn;
      lowD      <= lowIn;
      state     <= nextState;
      cnt       <= nextCnt;
      dtLatched <= nextDt;
      // Shoot-through blocks both drives only for the violating cycle.
      highOut   <= passOut & ~shoot & highIn;
      lowOut    <= passOut & ~shoot & lowIn;
      inDead    <= (nextState == DEAD);
      // A violation wins over a simultaneous clear.
      fault     <= shoot | (fault & ~clrFault);
    end
  end

endmodule : nonoverlap_ch

// File: rtl/nonoverlap_multi.sv
// -----------------------------------------------------------------------------
// nonoverlap_multi
//   Multi-channel dead-time (non-overlap) generator for half-bridge gate
//   drives. Sits between the PWM block and the gate-driver pins. Holds the
//   global enable edge detector and fans dead-time configuration and fault
//   clear out to NUM_CH independent channels.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   en          global enable; 0 forces all outputs low
//   dt_cfg      dead time: outputs held low dt_cfg+1 cycles per edge
//   clr_fault   synchronous clear of all fault flags
//   highIn      high-side commands, one bit per channel
//   lowIn       low-side commands, one bit per channel
//   highOut     high-side gate drives (registered)
//   lowOut      low-side gate drives (registered)
//   inDead      per-channel dead-window indicator
//   fault       per-channel sticky shoot-through flags
// -----------------------------------------------------------------------------
module nonoverlap_multi
  import nonoverlap_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  dt_cfg,
  input  logic              clr_fault,
  input  logic [NUM_CH-1:0] highIn,
  input  logic [NUM_CH-1:0] lowIn,
  output logic [NUM_CH-1:0] highOut,
  output logic [NUM_CH-1:0] lowOut,
  output logic [NUM_CH-1:0] inDead,
  output logic [NUM_CH-1:0] fault
);

  logic enD;
  logic enRise;

  // enD resets low, so an enable already high when reset releases still
  // produces a rising edge and a mandatory dead window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enD <= 1'b0;
    end else begin
      enD <= en;
    end
  end

  assign enRise = en & ~enD;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
    nonoverlap_ch #(
      .CNT_W (CNT_W)
    ) uCh (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .enRise   (enRise),
      .dtCfg    (dt_cfg),
      .clrFault (clr_fault),
      .highIn   (highIn[ch]),
      .lowIn    (lowIn[ch]),
      .highOut  (highOut[ch]),
      .lowOut   (lowOut[ch]),
      .inDead   (inDead[ch]),
      .fault    (fault[ch])
    );
  end

endmodule : nonoverlap_multi

// File: tb/tb_nonoverlap_multi.sv
// -----------------------------------------------------------------------------
// tb_nonoverlap_multi
//   Scoreboard bench for nonoverlap_multi (NUM_CH=2, CNT_W=5). The stimulus
//   process drives directed vectors on the falling edge and queues the
//   hand-derived expected outputs tagged with the rising-edge number after
//   which they must hold. A monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_nonoverlap_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 5;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [CNT_W-1:0]  dt_cfg;
  logic              clr_fault;
  logic [NUM_CH-1:0] highIn;
  logic [NUM_CH-1:0] lowIn;
  logic [NUM_CH-1:0] highOut;
  logic [NUM_CH-1:0] lowOut;
  logic [NUM_CH-1:0] inDead;
  logic [NUM_CH-1:0] fault;

  nonoverlap_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dt_cfg    (dt_cfg),
    .clr_fault (clr_fault),
    .highIn    (highIn),
    .lowIn     (lowIn),
    .highOut   (highOut),
    .lowOut    (lowOut),
    .inDead    (inDead),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter; at a falling edge it equals the edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         edgeNum;
    logic [7:0] expVal;
    string      name;
  } exp_t;

  exp_t sbQ[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got hi=%b lo=%b dead=%b flt=%b, want hi=%b lo=%b dead=%b flt=%b",
               name, cyc, act[7:6], act[5:4], act[3:2], act[1:0],
               exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic push(input int e, input logic [1:0] hi, input logic [1:0] lo,
                      input logic [1:0] dd, input logic [1:0] ff, input string nm);
    exp_t x;
    x.edgeNum = e;
    x.expVal  = {hi, lo, dd, ff};
    x.name    = nm;
    sbQ.push_back(x);
  endtask

  task automatic pushRange(input int first, input int last, input logic [1:0] hi,
                           input logic [1:0] lo, input logic [1:0] dd,
                           input logic [1:0] ff, input string nm);
    for (int i = first; i <= last; i++) push(i, hi, lo, dd, ff, nm);
  endtask

  // Advance to the falling edge that follows rising edge e.
  task automatic waitTo(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Monitor: compares the queued expectation for the edge just completed.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].edgeNum < cyc) begin
      cur = sbQ.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d was never compared (now %0d)",
               cur.name, cur.edgeNum, cyc);
    end
    if (sbQ.size() > 0 && sbQ[0].edgeNum == cyc) begin
      cur = sbQ.pop_front();
      check(cur.name, {highOut, lowOut, inDead, fault}, cur.expVal);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int k;
  int m;

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    dt_cfg    = '0;
    clr_fault = 1'b0;
    highIn    = '0;
    lowIn     = '0;

    // Reset, then idle with enable low.
    waitTo(3);
    push(4, 2'b00, 2'b00, 2'b00, 2'b00, "in_reset");
    waitTo(4);
    rst_n = 1'b1;
    push(5, 2'b00, 2'b00, 2'b00, 2'b00, "en_low_idle");
    waitTo(5);

    // Enable rising opens a one-cycle window (dt=0) on both channels.
    en = 1'b1;
    k = cyc + 1;
    push(k,     2'b00, 2'b00, 2'b11, 2'b00, "en_rise_dead");
    push(k + 1, 2'b00, 2'b00, 2'b00, 2'b00, "en_rise_done");
    waitTo(k + 2);

    // dt=31: 32 low cycles, dt_cfg change mid-window has no effect.
    dt_cfg = 5'd31;
    highIn = 2'b01;
    k = cyc + 1;
    pushRange(k, k + 31, 2'b00, 2'b00, 2'b01, 2'b00, "dt31_window");
    push(k + 32, 2'b01, 2'b00, 2'b00, 2'b00, "dt31_follow");
    push(k + 33, 2'b01, 2'b00, 2'b00, 2'b00, "dt31_hold");
    waitTo(k + 5);
    dt_cfg = 5'd3;
    waitTo(k + 33);

    // Falling edge with dt=3: output drops at once, window k..k+3.
    highIn = 2'b00;
    k = cyc + 1;
    pushRange(k, k + 3, 2'b00, 2'b00, 2'b01, 2'b00, "dt3_fall_window");
    push(k + 4, 2'b00, 2'b00, 2'b00, 2'b00, "dt3_fall_done");
    waitTo(k + 4);

    // Window restart: lowIn edges seen at k, k+1, k+2 -> low until k+5.
    lowIn = 2'b01;
    k = cyc + 1;
    pushRange(k, k + 5, 2'b00, 2'b00, 2'b01, 2'b00, "restart_window");
    push(k + 6, 2'b00, 2'b01, 2'b00, 2'b00, "restart_follow");
    waitTo(k);
    lowIn = 2'b00;
    waitTo(k + 1);
    lowIn = 2'b01;
    waitTo(k + 6);

    lowIn = 2'b00;
    k = cyc + 1;
    pushRange(k, k + 3, 2'b00, 2'b00, 2'b01, 2'b00, "low_fall_window");
    push(k + 4, 2'b00, 2'b00, 2'b00, 2'b00, "low_fall_done");
    waitTo(k + 4);

    // Shoot-through on ch1 for two cycles; ch0 stays clean.
    highIn = 2'b10;
    lowIn  = 2'b10;
    k = cyc + 1;
    pushRange(k, k + 5, 2'b00, 2'b00, 2'b10, 2'b10, "shoot_window");
    push(k + 6, 2'b00, 2'b00, 2'b00, 2'b10, "shoot_sticky");
    waitTo(k + 1);
    highIn = 2'b00;
    lowIn  = 2'b00;
    waitTo(k + 6);

    clr_fault = 1'b1;
    k = cyc + 1;
    push(k, 2'b00, 2'b00, 2'b00, 2'b00, "clr_fault");
    waitTo(k);
    clr_fault = 1'b0;
    push(k + 1, 2'b00, 2'b00, 2'b00, 2'b00, "clr_hold");
    waitTo(k + 1);

    // Clear and violation on ch0 in the same cycle: fault stays set.
    clr_fault = 1'b1;
    highIn    = 2'b01;
    lowIn     = 2'b01;
    k = cyc + 1;
    push(k, 2'b00, 2'b00, 2'b01, 2'b01, "clr_vs_violation");
    pushRange(k + 1, k + 4, 2'b00, 2'b00, 2'b01, 2'b01, "clr_vs_window");
    push(k + 5, 2'b00, 2'b00, 2'b00, 2'b01, "fault_sticky_ch0");
    waitTo(k);
    clr_fault = 1'b0;
    highIn    = 2'b00;
    lowIn     = 2'b00;
    waitTo(k + 5);

    clr_fault = 1'b1;
    k = cyc + 1;
    push(k, 2'b00, 2'b00, 2'b00, 2'b00, "clr_fault2");
    waitTo(k);
    clr_fault = 1'b0;

    // dt=0: exactly one forced-low cycle.
    dt_cfg = 5'd0;
    highIn = 2'b01;
    k = cyc + 1;
    push(k,     2'b00, 2'b00, 2'b01, 2'b00, "dt0_window");
    push(k + 1, 2'b01, 2'b00, 2'b00, 2'b00, "dt0_follow");
    push(k + 2, 2'b01, 2'b00, 2'b00, 2'b00, "dt0_hold");
    waitTo(k + 2);

    // Enable dropped mid-window, then re-enabled with highIn=1, dt=5.
    dt_cfg = 5'd5;
    highIn = 2'b00;
    k = cyc + 1;
    push(k,     2'b00, 2'b00, 2'b01, 2'b00, "en_drop_pre0");
    push(k + 1, 2'b00, 2'b00, 2'b01, 2'b00, "en_drop_pre1");
    waitTo(k + 1);
    en = 1'b0;
    push(k + 2, 2'b00, 2'b00, 2'b00, 2'b00, "en_drop_forces");
    push(k + 3, 2'b00, 2'b00, 2'b00, 2'b00, "en_low_idle2");
    waitTo(k + 3);
    highIn = 2'b01;
    push(k + 4, 2'b00, 2'b00, 2'b00, 2'b00, "en0_gates_high");
    push(k + 5, 2'b00, 2'b00, 2'b00, 2'b00, "en0_gates_high2");
    waitTo(k + 5);
    en = 1'b1;
    m = cyc + 1;
    pushRange(m, m + 5, 2'b00, 2'b00, 2'b11, 2'b00, "en_rise_window");
    push(m + 6, 2'b01, 2'b00, 2'b00, 2'b00, "en_rise_follow");
    waitTo(m + 6);
    en = 1'b0;
    push(m + 7, 2'b00, 2'b00, 2'b00, 2'b00, "en0_steady_high");
    waitTo(m + 7);
    dt_cfg = 5'd0;
    en = 1'b1;
    k = cyc + 1;
    push(k,     2'b00, 2'b00, 2'b11, 2'b00, "reen_dead");
    push(k + 1, 2'b01, 2'b00, 2'b00, 2'b00, "reen_follow");
    waitTo(k + 1);

    // Asynchronous reset between edges in the middle of a long window.
    dt_cfg = 5'd31;
    highIn = 2'b00;
    clr_fault = 1'b0;
    k = cyc + 1;
    pushRange(k, k + 2, 2'b00, 2'b00, 2'b01, 2'b00, "pre_reset_window");
    waitTo(k + 2);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {highOut, lowOut, inDead, fault}, 8'h00);
    @(negedge clk);
    rst_n  = 1'b1;
    dt_cfg = 5'd0;
    k = cyc + 1;
    push(k,     2'b00, 2'b00, 2'b11, 2'b00, "resume_en_dead");
    push(k + 1, 2'b00, 2'b00, 2'b00, 2'b00, "resume_idle");
    waitTo(k + 1);
    highIn = 2'b01;
    k = cyc + 1;
    push(k,     2'b00, 2'b00, 2'b01, 2'b00, "resume_edge");
    push(k + 1, 2'b01, 2'b00, 2'b00, 2'b00, "resume_follow");
    waitTo(k + 2);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(negedge clk);
    if (sbQ.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sbQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nonoverlap_multi
